// File: rtl/sequenciador_ciclo.sv
// rtl/sequenciador_ciclo.sv - multicycle phase sequencer driving the datapath estado bus
// Optional MEM-stall watchdog enabled by defining SEQ_WATCHDOG_EN.
module sequenciador_ciclo #(
    parameter int WAIT_EX  = 2,
    parameter int WAIT_WB  = 2,
    parameter int WDOG_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_mode,
    input  logic        step,
    input  logic [31:0] instrucao,
    input  logic        mem_ready,
    output logic [3:0]  estado,
    output logic        finalizado,
    output logic        busy,
    output logic [15:0] instret,
    output logic        erro
);
    typedef enum logic [3:0] {
        S_IF    = 4'b0000,
        S_ID    = 4'b0001,
        S_EX    = 4'b0010,
        S_MEM   = 4'b0011,
        S_WB    = 4'b0100,
        S_WEX   = 4'b0101,
        S_WWB   = 4'b0110,
        S_SUMPC = 4'b1000,
        S_FIM   = 4'b1001,
        S_HOLD  = 4'b1010
    } fase_t;

    fase_t       fase, fase_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        step_q;
    logic        wdog_hit;

    if (WAIT_EX < 0 || WAIT_EX > 15 || WAIT_WB < 0 || WAIT_WB > 15 || WDOG_MAX < 1) begin : g_param_check
        $error("sequenciador_ciclo: wait or watchdog parameter out of range");
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_MAX + 1);
    logic [WDW-1:0] stall_cnt;
    logic           erro_q;

    // Fires on the WDOG_MAX-th consecutive stalled MEM cycle.
    assign wdog_hit = (fase == S_MEM) && !mem_ready && (stall_cnt == WDW'(WDOG_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            erro_q    <= 1'b0;
        end else begin
            if (fase == S_MEM && !mem_ready) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
            if (wdog_hit) begin
                erro_q <= 1'b1;
            end
        end
    end

    assign erro = erro_q;
`else
    assign wdog_hit = 1'b0;
    assign erro     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fase    <= S_IF;
            cnt     <= 4'd0;
            step_q  <= 1'b0;
            instret <= 16'd0;
        end else begin
            fase   <= fase_nxt;
            cnt    <= cnt_nxt;
            step_q <= step;
            if (fase == S_SUMPC) begin
                instret <= instret + 16'd1;
            end
        end
    end

    always_comb begin
        fase_nxt = fase;
        cnt_nxt  = cnt;
        case (fase)
            S_IF:    fase_nxt = S_ID;
            S_ID:    fase_nxt = (instrucao == 32'h0) ? S_FIM : S_EX;
            S_EX: begin
                if (WAIT_EX > 0) begin
                    fase_nxt = S_WEX;
                    cnt_nxt  = 4'(WAIT_EX - 1);
                end else begin
                    fase_nxt = S_MEM;
                end
            end
            S_WEX: begin
                if (cnt == 4'd0) begin
                    fase_nxt = S_MEM;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_MEM: begin
                if (wdog_hit) begin
                    fase_nxt = S_FIM;
                end else if (mem_ready) begin
                    fase_nxt = S_WB;
                end
            end
            S_WB: begin
                if (WAIT_WB > 0) begin
                    fase_nxt = S_WWB;
                    cnt_nxt  = 4'(WAIT_WB - 1);
                end else begin
                    fase_nxt = S_SUMPC;
                end
            end
            S_WWB: begin
                if (cnt == 4'd0) begin
                    fase_nxt = S_SUMPC;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_SUMPC: fase_nxt = run_mode ? S_IF : S_HOLD;
            // A step edge already seen in SUMPC is absorbed by step_q and cannot release HOLD.
            S_HOLD: begin
                if (run_mode || (step && !step_q)) begin
                    fase_nxt = S_IF;
                end
            end
            S_FIM:   fase_nxt = S_FIM;
            default: fase_nxt = S_IF;
        endcase
    end

    assign estado     = fase;
    // "final" is a reserved word, so the sticky finish flag is exposed as finalizado.
    assign finalizado = (fase == S_FIM);
    assign busy       = !(fase == S_HOLD || fase == S_FIM);

endmodule
